// File: rtl/uart_pkg.sv
// Shared UART definitions: framing FSM states, status register bit positions
// and the default baud divider. Used by both the transmit and receive registers.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    localparam int UART_READY_BIT  = 31;
    localparam int UART_ACTIVE_BIT = 30;
    localparam int UART_SEND_BIT   = 31;

    // 10 MHz system clock, 115200 baud
    localparam int UART_CLKS_PER_BIT_DEF = 87;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular TX byte queue with wrap-around pointers; an extra pointer bit
// distinguishes full from empty. Only instantiated when UART_TX_FIFO_EN is set.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage carries no reset; only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_mem.sv
// Memory-mapped 8N1 UART transmitter. Define UART_TX_FIFO_EN for a FIFO_DEPTH
// queue; otherwise a single holding register buffers one byte ahead.
module uart_tx_mem
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_wen,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        o_tx_serial,
    output logic        o_tx_active,
    output logic        o_tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_mem: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_mem: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    uart_state_e      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       last_byte;
    logic             tx_serial;
    logic             tx_active;
    logic             tx_done;

    logic             q_full;
    logic             q_empty;
    logic [7:0]       q_dout;
    logic             ready;
    logic             accept;
    logic             dequeue;

    assign ready  = !q_full;
    assign accept = mem_wen && mem_wdata[UART_SEND_BIT] && ready;

    // Dequeue from IDLE, or on the last STOP cycle to chain frames without a gap
    always_comb begin
        dequeue = 1'b0;
        if (!q_empty) begin
            if (state == UART_IDLE) begin
                dequeue = 1'b1;
            end else if (state == UART_STOP && baud_cnt == CNT_LAST) begin
                dequeue = 1'b1;
            end
        end
    end

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (mem_wdata[7:0]),
        .pop   (dequeue),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    // accept needs hold_valid=0 and dequeue needs hold_valid=1, so they never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
        end else if (dequeue) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= mem_wdata[7:0];
        end
    end

    assign q_full  = hold_valid;
    assign q_empty = !hold_valid;
    assign q_dout  = hold_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_byte <= 8'h00;
        end else if (accept) begin
            last_byte <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (dequeue) begin
            shift <= q_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UART_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // Registered so the pulse lands on the final STOP cycle
            tx_done <= (state == UART_STOP) && (baud_cnt == CNT_DONE);
            case (state)
                UART_IDLE: begin
                    if (!q_empty) begin
                        baud_cnt  <= '0;
                        state     <= UART_START;
                        tx_serial <= 1'b0;
                        tx_active <= 1'b1;
                    end
                end
                UART_START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt  <= '0;
                        bit_idx   <= 3'd0;
                        state     <= UART_DATA;
                        tx_serial <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                UART_DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state     <= UART_STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_serial <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                UART_STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (!q_empty) begin
                            state     <= UART_START;
                            tx_serial <= 1'b0;
                        end else begin
                            state     <= UART_IDLE;
                            tx_active <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= UART_IDLE;
                    tx_serial <= 1'b1;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_rdata                  = '0;
        mem_rdata[UART_READY_BIT]  = ready;
        mem_rdata[UART_ACTIVE_BIT] = tx_active;
        mem_rdata[7:0]             = last_byte;
    end

    assign o_tx_serial = tx_serial;
    assign o_tx_active = tx_active;
    assign o_tx_done   = tx_done;

endmodule

// File: tb/tb_uart_tx_mem.sv
// Directed bench for uart_tx_mem with CLKS_PER_BIT=4; outputs are logged every
// falling edge and compared against hand-derived 8N1 waveforms.
module tb_uart_tx_mem;

    localparam int CPB  = 4;
    localparam int LOGN = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        o_tx_serial;
    logic        o_tx_active;
    logic        o_tx_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        log_ser  [LOGN];
    logic        log_act  [LOGN];
    logic        log_done [LOGN];
    logic [31:0] log_rd   [LOGN];

    uart_tx_mem #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_wen     (mem_wen),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .o_tx_serial (o_tx_serial),
        .o_tx_active (o_tx_active),
        .o_tx_done   (o_tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_ser[cyc]  = o_tx_serial;
            log_act[cyc]  = o_tx_active;
            log_done[cyc] = o_tx_done;
            log_rd[cyc]   = mem_rdata;
        end
    end

    // Expected line level for frame bit k: 0 start, 1..8 data LSB first, 9 stop
    function automatic logic line_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic do_write(input logic [31:0] d, output int t0);
        @(negedge clk);
        mem_wen   = 1'b1;
        mem_wdata = d;
        @(negedge clk);
        mem_wen   = 1'b0;
        mem_wdata = 32'h0;
        t0 = cyc;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_tx_serial !== 1'b1) begin
            errors++; $display("FAIL reset_serial got %b exp 1", o_tx_serial);
        end
        checks++;
        if (mem_rdata !== 32'h80000000) begin
            errors++; $display("FAIL reset_rdata got %h exp 80000000", mem_rdata);
        end
        checks++;
        if (o_tx_done !== 1'b0 || o_tx_active !== 1'b0) begin
            errors++; $display("FAIL reset_done_active got %b%b exp 00", o_tx_done, o_tx_active);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_tx_serial !== 1'b1 || o_tx_active !== 1'b0 || mem_rdata !== 32'h80000000) begin
            errors++; $display("FAIL post_reset_idle got ser=%b act=%b rd=%h exp 1 0 80000000",
                               o_tx_serial, o_tx_active, mem_rdata);
        end
    endtask

    task automatic test_single_frame();
        int t0;
        logic [7:0] b;
        logic [31:0] rd_exp;
        b = 8'hA5;
        do_write(32'h800000A5, t0);
        wait_until(t0 + 43);
`ifdef UART_TX_FIFO_EN
        rd_exp = 32'h800000A5;
`else
        rd_exp = 32'h000000A5;
`endif
        checks++;
        if (log_ser[t0] !== 1'b1) begin
            errors++; $display("FAIL single_before_start got %b exp 1", log_ser[t0]);
        end
        checks++;
        if (log_rd[t0] !== rd_exp) begin
            errors++; $display("FAIL single_rdata_after_write got %h exp %h", log_rd[t0], rd_exp);
        end
        checks++;
        if (log_rd[t0+1] !== 32'hC00000A5) begin
            errors++; $display("FAIL single_rdata_active got %h exp c00000a5", log_rd[t0+1]);
        end
        for (int i = 0; i < 10*CPB; i++) begin
            checks++;
            if (log_ser[t0+1+i] !== line_bit(b, i/CPB) || log_act[t0+1+i] !== 1'b1 ||
                log_done[t0+1+i] !== (i == 10*CPB-1)) begin
                errors++;
                $display("FAIL single_frame[%0d] got ser=%b act=%b done=%b exp ser=%b act=1 done=%b",
                         i, log_ser[t0+1+i], log_act[t0+1+i], log_done[t0+1+i],
                         line_bit(b, i/CPB), (i == 10*CPB-1));
            end
        end
        checks++;
        if (log_ser[t0+41] !== 1'b1 || log_act[t0+41] !== 1'b0 || log_done[t0+41] !== 1'b0 ||
            log_rd[t0+41] !== 32'h800000A5) begin
            errors++; $display("FAIL single_end got ser=%b act=%b done=%b rd=%h exp 1 0 0 800000a5",
                               log_ser[t0+41], log_act[t0+41], log_done[t0+41], log_rd[t0+41]);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        logic [7:0] bytes [2];
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        do_write(32'h80000011, t0);
        do_write(32'h80000022, t1);
        wait_until(t0 + 83);
        for (int i = 0; i < 20*CPB; i++) begin
            checks++;
            if (log_ser[t0+1+i] !== line_bit(bytes[i/(10*CPB)], (i%(10*CPB))/CPB) ||
                log_act[t0+1+i] !== 1'b1 ||
                log_done[t0+1+i] !== ((i%(10*CPB)) == 10*CPB-1)) begin
                errors++;
                $display("FAIL b2b_frame[%0d] got ser=%b act=%b done=%b exp ser=%b act=1 done=%b",
                         i, log_ser[t0+1+i], log_act[t0+1+i], log_done[t0+1+i],
                         line_bit(bytes[i/(10*CPB)], (i%(10*CPB))/CPB),
                         ((i%(10*CPB)) == 10*CPB-1));
            end
        end
        checks++;
        if (log_act[t0+81] !== 1'b0 || log_rd[t0+81] !== 32'h80000022) begin
            errors++; $display("FAIL b2b_end got act=%b rd=%h exp 0 80000022",
                               log_act[t0+81], log_rd[t0+81]);
        end
    endtask

    task automatic test_ignored_write();
        int t0;
        do_write(32'h000000FF, t0);
        wait_until(t0 + 28);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (log_ser[t0+i] !== 1'b1 || log_act[t0+i] !== 1'b0 || log_rd[t0+i] !== 32'h80000022) begin
                errors++;
                $display("FAIL ignored[%0d] got ser=%b act=%b rd=%h exp 1 0 80000022",
                         i, log_ser[t0+i], log_act[t0+i], log_rd[t0+i]);
            end
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_overflow();
        int t0;
        logic [7:0] b;
        t0 = 0;
        @(negedge clk);
        mem_wen = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mem_wdata = 32'h80000061 + k;
            @(negedge clk);
            if (k == 0) t0 = cyc;
        end
        mem_wen   = 1'b0;
        mem_wdata = 32'h0;
        wait_until(t0 + 203);
        checks++;
        if (log_rd[t0+3][31] !== 1'b1) begin
            errors++; $display("FAIL ovf_ready_3 got %b exp 1", log_rd[t0+3][31]);
        end
        checks++;
        if (log_rd[t0+4][31] !== 1'b0 || log_rd[t0+5][31] !== 1'b0) begin
            errors++; $display("FAIL ovf_ready_full got %b%b exp 00", log_rd[t0+4][31], log_rd[t0+5][31]);
        end
        for (int i = 0; i < 50*CPB; i++) begin
            b = 8'h61 + 8'(i/(10*CPB));
            checks++;
            if (log_ser[t0+1+i] !== line_bit(b, (i%(10*CPB))/CPB) || log_act[t0+1+i] !== 1'b1 ||
                log_done[t0+1+i] !== ((i%(10*CPB)) == 10*CPB-1)) begin
                errors++;
                $display("FAIL ovf_frame[%0d] got ser=%b act=%b done=%b exp ser=%b act=1",
                         i, log_ser[t0+1+i], log_act[t0+1+i], log_done[t0+1+i],
                         line_bit(b, (i%(10*CPB))/CPB));
            end
        end
        checks++;
        if (log_act[t0+201] !== 1'b0 || log_ser[t0+201] !== 1'b1 || log_rd[t0+201] !== 32'h80000065) begin
            errors++; $display("FAIL ovf_end got act=%b ser=%b rd=%h exp 0 1 80000065",
                               log_act[t0+201], log_ser[t0+201], log_rd[t0+201]);
        end
    endtask
`else
    task automatic test_drop_when_busy();
        int t0;
        logic [7:0] bytes [2];
        bytes[0] = 8'h33;
        bytes[1] = 8'h55;
        t0 = 0;
        @(negedge clk);
        mem_wen   = 1'b1;
        mem_wdata = 32'h80000033;
        @(negedge clk);
        t0 = cyc;
        mem_wdata = 32'h80000044;
        @(negedge clk);
        mem_wdata = 32'h80000055;
        @(negedge clk);
        mem_wen   = 1'b0;
        mem_wdata = 32'h0;
        wait_until(t0 + 83);
        checks++;
        if (log_rd[t0+1] !== 32'hC0000033) begin
            errors++; $display("FAIL drop_rdata got %h exp c0000033", log_rd[t0+1]);
        end
        for (int i = 0; i < 20*CPB; i++) begin
            checks++;
            if (log_ser[t0+1+i] !== line_bit(bytes[i/(10*CPB)], (i%(10*CPB))/CPB) ||
                log_act[t0+1+i] !== 1'b1 ||
                log_done[t0+1+i] !== ((i%(10*CPB)) == 10*CPB-1)) begin
                errors++;
                $display("FAIL drop_frame[%0d] got ser=%b act=%b done=%b exp ser=%b act=1",
                         i, log_ser[t0+1+i], log_act[t0+1+i], log_done[t0+1+i],
                         line_bit(bytes[i/(10*CPB)], (i%(10*CPB))/CPB));
            end
        end
        checks++;
        if (log_act[t0+81] !== 1'b0 || log_rd[t0+81] !== 32'h80000055) begin
            errors++; $display("FAIL drop_end got act=%b rd=%h exp 0 80000055",
                               log_act[t0+81], log_rd[t0+81]);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int t0;
        int t1;
        int tr;
        do_write(32'h800000C3, t0);
        do_write(32'h8000005A, t1);
        wait_until(t0 + 18);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (o_tx_serial !== 1'b1 || o_tx_active !== 1'b0 || o_tx_done !== 1'b0) begin
            errors++; $display("FAIL midrst_async got ser=%b act=%b done=%b exp 1 0 0",
                               o_tx_serial, o_tx_active, o_tx_done);
        end
        checks++;
        if (mem_rdata !== 32'h80000000) begin
            errors++; $display("FAIL midrst_rdata got %h exp 80000000", mem_rdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tr = cyc;
        wait_until(tr + 52);
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (log_ser[tr+i] !== 1'b1 || log_act[tr+i] !== 1'b0 || log_done[tr+i] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_flushed[%0d] got ser=%b act=%b done=%b exp 1 0 0",
                         i, log_ser[tr+i], log_act[tr+i], log_done[tr+i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_write();
`ifdef UART_TX_FIFO_EN
        test_overflow();
`else
        test_drop_when_busy();
`endif
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_mem.md
# uart_tx_mem

Memory-mapped UART transmitter: the CPU writes a byte to a single 32-bit register, and the block serialises it as 8N1 (one start bit, 8 data bits LSB first, one stop bit, no parity) on `o_tx_serial`. It sits on the CPU data-memory bus beside the UART receive register. It is the transmit counterpart of that register and uses the same bit-31 handshake. It contains the holding storage, the baud counter and the framing state machine.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per serial bit (10 MHz / 115200). Minimum legal value is 2.
- `FIFO_DEPTH`, default 4: number of TX queue entries. Must be a power of 2 and at least 2. Used only with `UART_TX_FIFO_EN`.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_wen` input 1: register write strobe, one cycle per write.
- `mem_wdata` input 32: write data. Bit 31 is the SEND request; bits 7:0 are the byte.
- `mem_rdata` output 32: status. Bit 31 is READY, bit 30 is ACTIVE, bits 29:8 are 0, bits 7:0 hold the last accepted byte.
- `o_tx_serial` output 1: serial line. Idles high.
- `o_tx_active` output 1: high while a frame is on the line (START, DATA or STOP).
- `o_tx_done` output 1: one-cycle pulse when a frame's stop bit completes.

## Operation
- **Reset values:** `o_tx_serial`=1, `o_tx_active`=0, `o_tx_done`=0, READY=1, last byte=0x00, queue empty, FSM in IDLE.
- **Accepting a write:** a write is accepted when `mem_wen`=1, `mem_wdata[31]`=1 and READY=1, all sampled at the same edge. The byte is enqueued and the last-byte field is updated.
- **Ignored writes:**
  - A write with bit 31=0 is ignored.
  - A write with READY=0 is dropped silently, even if a dequeue happens on the same edge.
- **READY:** READY = queue not full. READY is evaluated from the state before the clock edge.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** if the queue is non-empty, dequeue the head into the shift register, clear the baud counter and go to START.
- **START:** drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index at 0.
- **DATA:** drive `shift[idx]` for `CLKS_PER_BIT` cycles. Then increment idx; when idx 7 completes, go to STOP.
- **STOP:** drive 1 for `CLKS_PER_BIT` cycles. On the final cycle, pulse `o_tx_done`. Then:
  - if the queue is non-empty, dequeue the next byte and go directly to START (no idle gap);
  - otherwise go to IDLE.
- **Counter widths:**
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits and wraps at `CLKS_PER_BIT`-1.
  - The bit index is 3 bits.
- **Reset mid-frame:** the line returns high immediately (asynchronously), the frame is abandoned and the queue is flushed.

## Timing
- **Write-to-start latency:** a write accepted at edge E0 is dequeued at E1 if the FSM is idle. `o_tx_serial` falls after E1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles. Every bit lasts exactly `CLKS_PER_BIT` cycles.
- **`o_tx_done`:** high during the last cycle of STOP, registered.
- **`o_tx_active`:** high from the edge that enters START to the edge that leaves STOP into IDLE. It stays continuously high across back-to-back frames.
- **`mem_rdata`:** combinational from registered state. A write's effect is visible the cycle after the write.

## Configuration
- **`UART_TX_FIFO_EN` defined:** a `FIFO_DEPTH`-entry circular queue with wrap-around pointers and full/empty flags. A simultaneous enqueue and dequeue when full is not possible, because READY=0 blocks the enqueue.
- **`UART_TX_FIFO_EN` undefined:** a single holding register; READY = !hold_valid.
  - The holding register is freed on the dequeue edge, so the CPU may write the next byte while the current frame is shifting.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`);
  - register bit positions `UART_READY_BIT`=31 and `UART_ACTIVE_BIT`=30;
  - default `CLKS_PER_BIT`.
  - The receive side shares this package.
- **Sub-module `uart_tx_fifo`:** the queue, parameterised by depth and 8-bit width, with push/pop/full/empty/dout. It is instantiated only under `UART_TX_FIFO_EN`.

## Test plan
- **Reset values:** assert `rst_n`=0 → `o_tx_serial`=1, `mem_rdata`=0x80000000, `o_tx_done`=0.
- **Single frame:** with `CLKS_PER_BIT`=4, write 0x800000A5 → the line carries 0, 1,0,1,0,0,1,0,1, 1, each bit for 4 cycles. The line falls 1 cycle after the write. `o_tx_done` pulses at cycle 40 of the frame. `mem_rdata[7:0]`=0xA5.
- **Back-to-back writes:** write 0x80000011 then 0x80000022 back-to-back → two frames with no idle cycle between them. `o_tx_active` stays high for 80 cycles; `o_tx_done` pulses twice.
- **Overflow (FIFO build):** with FIFO_DEPTH=4, write 6 bytes in consecutive cycles → READY=0 after the queue fills; the 6th byte is dropped. Exactly 5 frames are sent (one dequeued immediately, four queued).
- **Ignored write:** write 0x000000FF → no frame is sent, READY stays 1, last byte unchanged.
- **Reset mid-frame:** pulse `rst_n` low during DATA bit 3 → the line goes high immediately, `o_tx_active`=0, the queue is empty, and no `o_tx_done` pulse occurs.
